supercar_scanner: RTL and testbench
===================================

# supercar_scanner

Tick-driven "supercar" LED scanner: a single lit LED moves one position per input tick from LED 0 up to LED N_LED-1, optionally dwells at each end, then returns, bouncing forever. It is the consumer of the one-cycle period pulse produced by the prescaler: it samples that pulse as its `tick` input and advances exactly once per pulse. It sits between the prescaler and the board LED pins.

## Interface
- N_LED, 8, number of LEDs; legal range 2..32, elaboration error outside it
- DWELL, 0, extra ticks the lit LED holds at each end before reversing; legal range 0..15
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- en  input  1  scanner enable; when low, ticks are ignored and all state is held
- clr  input  1  synchronous restart to the reset state; priority over `tick`
- tick  input  1  advance request, one-cycle pulse from the prescaler; may be held high for consecutive cycles, each sampled high cycle counts as one tick
- led  output  N_LED  one-hot lit-LED vector, registered
- pos  output  $clog2(N_LED)  binary index of the lit LED, registered, always matches `led`
- dir  output  1  0 = moving up (toward N_LED-1), 1 = moving down; registered
- bounce  output  1  one-cycle pulse, registered, marks arrival at an end position

## Operation
- States: UP, DWELL_HI, DOWN, DWELL_LO. Dwell counter `dcnt`, 4 bits.
- Advance condition: `adv = en & tick & ~clr`. Nothing changes without `adv` except via `clr`/`rst`.
- UP on adv: pos <= pos+1. If new pos == N_LED-1: bounce <= 1; go DWELL_HI with dcnt <= 0 when DWELL > 0, else go DOWN and dir <= 1.
- DWELL_HI on adv: pos unchanged; dcnt <= dcnt+1; when dcnt == DWELL-1, go DOWN, dir <= 1, dcnt <= 0.
- DOWN on adv: pos <= pos-1. If new pos == 0: bounce <= 1; go DWELL_LO (DWELL > 0) else go UP and dir <= 0.
- DWELL_LO: mirror of DWELL_HI, exits to UP with dir <= 0.
- `dir` is 0 in UP and DWELL_LO, 1 in DOWN and DWELL_HI.
- `led` = 1 << pos at all times; never zero, never multi-hot.
- pos never leaves 0..N_LED-1; no wrap-around arithmetic is permitted.
- Scan period in ticks: 2*(N_LED-1) + 2*DWELL.
- `bounce` is 0 in every cycle without a qualifying adv; it is never high for two consecutive cycles unless two consecutive adv events each reach an end, which only occurs with N_LED = 2 and DWELL = 0.
- en low mid-dwell or mid-scan: freeze exactly; resume from the same state and dcnt when en returns.
- clr in any state, with or without tick: next edge gives the reset state and bounce = 0.

## Timing
- Reset (rst low, asynchronous, immediate): state UP, pos = 0, led = 1, dir = 0, bounce = 0, dcnt = 0.
- Deassertion of rst is synchronized externally. The first edge after release may already act on tick.
- Latency: `tick` sampled high at edge k, so outputs reflect the new position after edge k. One-cycle latency, no combinational path from inputs to outputs.
- `bounce` is asserted in the same cycle that `pos` first shows the end value.
- Back-to-back ticks on consecutive cycles are all honored, one step each.

## Test plan
- Reset/idle: hold rst low, then release with tick = 0 for 20 cycles -> led = 8'h01, pos = 0, dir = 0, bounce = 0 throughout.
- Full sweep, N_LED = 8, DWELL = 0, tick every 10 cycles -> pos sequence 0,1..7,6..0,1; bounce high one cycle at pos 7 and at pos 0; dir flips on the tick reaching 7; period of 14 ticks.
- Dwell, DWELL = 2 -> pos 7 held for 3 consecutive ticks (arrive plus 2 dwell), then 6; bounce only on arrival; period of 18 ticks.
- Enable/clear priority: drop en for 5 ticks mid-DWELL_HI -> no change, and dwell resumes with the same remaining count; assert clr together with tick at pos 5 -> next cycle pos = 0, dir = 0, bounce = 0.
- Continuous tick (tick held high 30 cycles), N_LED = 2, DWELL = 0 -> pos toggles 1,0,1,0 every cycle; bounce high every cycle; led is always one-hot.
- Async reset mid-scan: pull rst low between clock edges at pos 4, DOWN -> outputs go to reset values before the next edge and stay there until release.

Source files
------------

// File: rtl/supercar_scanner.sv
// Tick-driven bouncing single-LED scanner with optional dwell at each end.
// Consumes the prescaler's one-cycle period pulse; every output is registered.
module supercar_scanner #(
    parameter int N_LED = 8,
    parameter int DWELL = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     tick,
    output logic [N_LED-1:0]         led,
    output logic [$clog2(N_LED)-1:0] pos,
    output logic                     dir,
    output logic                     bounce
);

    localparam int PW = $clog2(N_LED);
    localparam logic [PW-1:0] POS_LAST   = PW'(N_LED - 1);
    localparam logic [PW-1:0] POS_PENULT = PW'(N_LED - 2);
    localparam logic [PW-1:0] POS_ONE    = PW'(1);
    localparam logic [PW-1:0] POS_ZERO   = PW'(0);
    localparam logic [3:0]    DWELL_LAST = (DWELL > 0) ? 4'(DWELL - 1) : 4'd0;
    localparam bit            HAS_DWELL  = (DWELL > 0);

    generate
        if ((N_LED < 2) || (N_LED > 32)) begin : g_bad_n_led
            $error("supercar_scanner: N_LED must be within 2..32");
        end
        if ((DWELL < 0) || (DWELL > 15)) begin : g_bad_dwell
            $error("supercar_scanner: DWELL must be within 0..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        UP       = 2'd0,
        DWELL_HI = 2'd1,
        DOWN     = 2'd2,
        DWELL_LO = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [PW-1:0]      pos_r, pos_s;
    logic [3:0]         dcnt_r, dcnt_s;
    logic               dir_r, dir_s;
    logic               bounce_r, bounce_s;
    logic [N_LED-1:0]   led_r, led_s;
    logic               adv_s;

    function automatic logic [N_LED-1:0] onehot(input logic [PW-1:0] p);
        logic [N_LED-1:0] one;
        one    = {{(N_LED-1){1'b0}}, 1'b1};
        onehot = one << p;
    endfunction

    assign adv_s = en & tick & ~clr;

    // Next-state, position, dwell count and bounce pulse.
    always_comb begin
        state_s  = state_r;
        pos_s    = pos_r;
        dcnt_s   = dcnt_r;
        bounce_s = 1'b0;
        if (clr) begin
            state_s = UP;
            pos_s   = POS_ZERO;
            dcnt_s  = 4'd0;
        end else if (adv_s) begin
            case (state_r)
                UP: begin
                    // Step only while below the top end; the guard keeps pos in range.
                    if (pos_r != POS_LAST) begin
                        pos_s = pos_r + POS_ONE;
                        if (pos_r == POS_PENULT) begin
                            bounce_s = 1'b1;
                            dcnt_s   = 4'd0;
                            if (HAS_DWELL) begin
                                state_s = DWELL_HI;
                            end else begin
                                state_s = DOWN;
                            end
                        end else begin
                            state_s = UP;
                        end
                    end else begin
                        state_s = DOWN;
                    end
                end
                DWELL_HI: begin
                    if (dcnt_r == DWELL_LAST) begin
                        state_s = DOWN;
                        dcnt_s  = 4'd0;
                    end else begin
                        dcnt_s  = dcnt_r + 4'd1;
                    end
                end
                DOWN: begin
                    if (pos_r != POS_ZERO) begin
                        pos_s = pos_r - POS_ONE;
                        if (pos_r == POS_ONE) begin
                            bounce_s = 1'b1;
                            dcnt_s   = 4'd0;
                            if (HAS_DWELL) begin
                                state_s = DWELL_LO;
                            end else begin
                                state_s = UP;
                            end
                        end else begin
                            state_s = DOWN;
                        end
                    end else begin
                        state_s = UP;
                    end
                end
                DWELL_LO: begin
                    if (dcnt_r == DWELL_LAST) begin
                        state_s = UP;
                        dcnt_s  = 4'd0;
                    end else begin
                        dcnt_s  = dcnt_r + 4'd1;
                    end
                end
                default: begin
                    state_s = UP;
                    pos_s   = POS_ZERO;
                    dcnt_s  = 4'd0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Direction follows the next state; LED vector is decoded from the next position.
    always_comb begin
        dir_s = 1'b0;
        led_s = onehot(pos_s);
        if ((state_s == DOWN) || (state_s == DWELL_HI)) begin
            dir_s = 1'b1;
        end else begin
            dir_s = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= UP;
            pos_r    <= POS_ZERO;
            dcnt_r   <= 4'd0;
            dir_r    <= 1'b0;
            bounce_r <= 1'b0;
            led_r    <= {{(N_LED-1){1'b0}}, 1'b1};
        end else begin
            state_r  <= state_s;
            pos_r    <= pos_s;
            dcnt_r   <= dcnt_s;
            dir_r    <= dir_s;
            bounce_r <= bounce_s;
            led_r    <= led_s;
        end
    end

    assign led    = led_r;
    assign pos    = pos_r;
    assign dir    = dir_r;
    assign bounce = bounce_r;

endmodule

// File: tb/tb_supercar_scanner.sv
// Directed, table-driven bench for supercar_scanner: three instances
// (8 LEDs no dwell, 8 LEDs dwell 2, 2 LEDs no dwell) sharing the same inputs.
module tb_supercar_scanner;

    logic clk;
    logic rst;
    logic en;
    logic clr;
    logic tick;

    logic [7:0] led_a;
    logic [2:0] pos_a;
    logic       dir_a;
    logic       bounce_a;
    logic [7:0] led_b;
    logic [2:0] pos_b;
    logic       dir_b;
    logic       bounce_b;
    logic [1:0] led_c;
    logic [0:0] pos_c;
    logic       dir_c;
    logic       bounce_c;

    int n_checks;
    int n_fail;

    supercar_scanner #(.N_LED(8), .DWELL(0)) u_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .tick(tick),
        .led(led_a), .pos(pos_a), .dir(dir_a), .bounce(bounce_a)
    );
    supercar_scanner #(.N_LED(8), .DWELL(2)) u_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .tick(tick),
        .led(led_b), .pos(pos_b), .dir(dir_b), .bounce(bounce_b)
    );
    supercar_scanner #(.N_LED(2), .DWELL(0)) u_c (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .tick(tick),
        .led(led_c), .pos(pos_c), .dir(dir_c), .bounce(bounce_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       clr;
        logic       tick;
        logic [2:0] pos;
        logic       dir;
        logic       bounce;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: drive at a falling edge, return at the next falling edge.
    task automatic cyc(input logic t, input logic e, input logic c);
        tick = t;
        en   = e;
        clr  = c;
        @(negedge clk);
    endtask

    task automatic chk_a(input string tag, input int p, input logic d, input logic b);
        logic [7:0] one;
        one = 8'd1;
        check({tag, ".a.pos"}, 32'(pos_a), 32'(p));
        check({tag, ".a.led"}, 32'(led_a), 32'(one << p));
        check({tag, ".a.dir"}, 32'(dir_a), 32'(d));
        check({tag, ".a.bounce"}, 32'(bounce_a), 32'(b));
    endtask

    task automatic chk_b(input string tag, input int p, input logic d, input logic b);
        logic [7:0] one;
        one = 8'd1;
        check({tag, ".b.pos"}, 32'(pos_b), 32'(p));
        check({tag, ".b.led"}, 32'(led_b), 32'(one << p));
        check({tag, ".b.dir"}, 32'(dir_b), 32'(d));
        check({tag, ".b.bounce"}, 32'(bounce_b), 32'(b));
    endtask

    vec_t vecs[$];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst  = 1'b0;
        en   = 1'b0;
        clr  = 1'b0;
        tick = 1'b0;

        // Reset state, then 20 idle cycles after release.
        repeat (3) @(negedge clk);
        chk_a("reset", 0, 1'b0, 1'b0);
        chk_b("reset", 0, 1'b0, 1'b0);
        check("reset.c.led", 32'(led_c), 32'd1);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            chk_a($sformatf("idle%0d", i), 0, 1'b0, 1'b0);
        end

        // Full sweep, enable gating and clear priority on the 8/0 instance.
        vecs = '{
            '{1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b1, 3'd7, 1'b1, 1'b1},
            '{1'b1, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1},
            '{1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0}
        };
        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].tick, vecs[i].en, vecs[i].clr);
            chk_a($sformatf("vec%0d", i), int'(vecs[i].pos), vecs[i].dir, vecs[i].bounce);
            for (int g = 0; g < 2; g++) begin
                cyc(1'b0, 1'b1, 1'b0);
                chk_a($sformatf("vec%0d.gap%0d", i, g), int'(vecs[i].pos), vecs[i].dir, 1'b0);
            end
        end

        // Dwell of 2 at both ends, with an enable drop in the middle of the top dwell.
        cyc(1'b0, 1'b1, 1'b1);
        chk_b("dw.clr", 0, 1'b0, 1'b0);
        for (int p = 1; p <= 6; p++) begin
            cyc(1'b1, 1'b1, 1'b0);
            chk_b($sformatf("dw.up%0d", p), p, 1'b0, 1'b0);
        end
        cyc(1'b1, 1'b1, 1'b0);
        chk_b("dw.arrive_hi", 7, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        chk_b("dw.hold_hi1", 7, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            chk_b($sformatf("dw.en_off%0d", i), 7, 1'b1, 1'b0);
        end
        cyc(1'b1, 1'b1, 1'b0);
        chk_b("dw.hold_hi2", 7, 1'b1, 1'b0);
        for (int p = 6; p >= 1; p--) begin
            cyc(1'b1, 1'b1, 1'b0);
            chk_b($sformatf("dw.down%0d", p), p, 1'b1, 1'b0);
        end
        cyc(1'b1, 1'b1, 1'b0);
        chk_b("dw.arrive_lo", 0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        chk_b("dw.hold_lo1", 0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk_b("dw.hold_lo2", 0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk_b("dw.restart", 1, 1'b0, 1'b0);

        // Two LEDs, tick held high: end reached on every cycle.
        cyc(1'b0, 1'b1, 1'b1);
        check("two.clr.pos", 32'(pos_c), 32'd0);
        for (int i = 1; i <= 30; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            check($sformatf("two%0d.pos", i), 32'(pos_c), 32'(i % 2));
            check($sformatf("two%0d.dir", i), 32'(dir_c), 32'(i % 2));
            check($sformatf("two%0d.bounce", i), 32'(bounce_c), 32'd1);
            check($sformatf("two%0d.led", i), 32'(led_c), (i % 2 == 1) ? 32'd2 : 32'd1);
        end

        // Asynchronous reset between edges while moving down at position 4.
        cyc(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
        end
        chk_a("ar.pre", 4, 1'b1, 1'b0);
        tick = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk_a("ar.immediate", 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            chk_a($sformatf("ar.held%0d", i), 0, 1'b0, 1'b0);
        end
        rst = 1'b1;
        cyc(1'b0, 1'b1, 1'b0);
        chk_a("ar.release", 0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk_a("ar.first_tick", 1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
